// File: rtl/lc3b_pkg.sv
// Shared definitions for the LC-3b ALU issue/writeback controller:
// opcodes, ALU control encodings, controller states and small helpers.
package lc3b_pkg;

    localparam int XLEN = 16;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SHF = 4'b1101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;
    localparam logic [1:0] ALU_SHF = 2'b11;

    localparam logic [1:0] SH_LSHF  = 2'b00;
    localparam logic [1:0] SH_RSHFL = 2'b01;
    localparam logic [1:0] SH_RSHFA = 2'b11;

    // {n,z,p} after reset: zero
    localparam logic [2:0] CC_RESET = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT,
        S_WB,
        S_BRANCH,
        S_ILL
    } state_t;

    function automatic logic [XLEN-1:0] sext5(input logic [4:0] imm);
        return {{(XLEN-5){imm[4]}}, imm};
    endfunction

    function automatic logic [1:0] alu_op_of(input logic [3:0] opcode);
        logic [1:0] op;
        op = ALU_ADD;
        case (opcode)
            OP_AND:  op = ALU_AND;
            OP_XOR:  op = ALU_XOR;
            OP_SHF:  op = ALU_SHF;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [2:0] cc_of(input logic [XLEN-1:0] v);
        logic n;
        logic z;
        n = v[XLEN-1];
        z = (v == '0);
        return {n, z, ~n & ~z};
    endfunction

endpackage

// File: rtl/lc3b_regfile.sv
// LC-3b general register file: two asynchronous read ports, one synchronous
// write port, cleared by synchronous reset.
module lc3b_regfile
    import lc3b_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      ra_addr,
    output logic [XLEN-1:0] ra_data,
    input  logic [2:0]      rb_addr,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [2:0]      w_addr,
    input  logic [XLEN-1:0] w_data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[w_addr] <= w_data;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/lc3b_alu_issue.sv
// Issue/writeback controller for the LC-3b ALU: accepts one instruction at a
// time, drives the ALU, writes back with NZP update and resolves BR.
module lc3b_alu_issue
    import lc3b_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [1:0]  alu_opval,
    output logic [1:0]  alu_shiftop,
    output logic [3:0]  alu_amount4,
    output logic [15:0] alu_a1,
    output logic [15:0] alu_a2,
    input  logic [15:0] alu_d,
    output logic        wb_valid,
    output logic [2:0]  wb_dr,
    output logic [15:0] wb_data,
    output logic        cc_n,
    output logic        cc_z,
    output logic        cc_p,
    output logic        br_valid,
    output logic        br_taken,
    output logic [8:0]  br_offset,
    output logic        illegal
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((ALU_LAT > 1) ? ALU_LAT - 2 : 0);

    state_t           state;
    logic [2:0]       dr;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       cc;
    logic [15:0]      wb_data_q;

    logic [3:0]  opcode;
    logic        is_alu_op;
    logic        accept;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic [15:0] a2_next;

    assign opcode    = instr[15:12];
    assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                       (opcode == OP_XOR) || (opcode == OP_SHF);
    assign accept    = instr_valid && instr_ready;

    // Operands are read straight from the incoming word at the accept edge so
    // the alu_* registers already hold them during the EXEC cycle.
    assign a2_next = (instr[5] && (opcode != OP_SHF)) ? sext5(instr[4:0]) : rb_data;

    lc3b_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (instr[8:6]),
        .ra_data (ra_data),
        .rb_addr (instr[2:0]),
        .rb_data (rb_data),
        .we      (state == S_WB),
        .w_addr  (dr),
        .w_data  (alu_d)
    );

    // wb_data is live ALU data during the writeback cycle and holds it after.
    assign wb_data = wb_valid ? alu_d : wb_data_q;
    assign {cc_n, cc_z, cc_p} = cc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            dr          <= '0;
            wait_cnt    <= '0;
            alu_opval   <= '0;
            alu_shiftop <= '0;
            alu_amount4 <= '0;
            alu_a1      <= '0;
            alu_a2      <= '0;
            wb_valid    <= 1'b0;
            wb_dr       <= '0;
            wb_data_q   <= '0;
            cc          <= CC_RESET;
            br_valid    <= 1'b0;
            br_taken    <= 1'b0;
            br_offset   <= '0;
            illegal     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            br_valid <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        instr_ready <= 1'b0;
                        dr          <= instr[11:9];
                        if (is_alu_op) begin
                            state       <= S_EXEC;
                            alu_opval   <= alu_op_of(opcode);
                            alu_shiftop <= instr[5:4];
                            alu_amount4 <= (opcode == OP_SHF) ? instr[3:0] : 4'd0;
                            alu_a1      <= ra_data;
                            alu_a2      <= a2_next;
                        end else if (opcode == OP_BR) begin
                            state     <= S_BRANCH;
                            br_valid  <= 1'b1;
                            br_taken  <= |(instr[11:9] & cc);
                            br_offset <= instr[8:0];
                        end else begin
                            state   <= S_ILL;
                            illegal <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    wait_cnt <= WAIT_INIT;
                    if (ALU_LAT == 1) begin
                        state    <= S_WB;
                        wb_valid <= 1'b1;
                        wb_dr    <= dr;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state    <= S_WB;
                        wb_valid <= 1'b1;
                        wb_dr    <= dr;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_WB: begin
                    wb_data_q   <= alu_d;
                    cc          <= cc_of(alu_d);
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_alu_issue.sv
// Bench for lc3b_alu_issue: two instances (ALU latency 1 and 3), a latency-
// accurate ALU responder, and a transaction-level model checked every cycle.
module tb_lc3b_alu_issue;
    import lc3b_pkg::*;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        iv [2];
    logic [15:0] iw [2];
    logic        rdy [2];
    logic [1:0]  opv [2];
    logic [1:0]  shop [2];
    logic [3:0]  amt [2];
    logic [15:0] a1 [2];
    logic [15:0] a2 [2];
    logic [15:0] alu_d [2];
    logic        wbv [2];
    logic [2:0]  wbdr [2];
    logic [15:0] wbd [2];
    logic        ccn [2];
    logic        ccz [2];
    logic        ccp [2];
    logic        brv [2];
    logic        brt [2];
    logic [8:0]  broff [2];
    logic        ill [2];

    lc3b_alu_issue #(.ALU_LAT(LAT0), .NREGS(8)) u_dut1 (
        .clk(clk), .reset(rst[0]), .instr_valid(iv[0]), .instr_ready(rdy[0]), .instr(iw[0]),
        .alu_opval(opv[0]), .alu_shiftop(shop[0]), .alu_amount4(amt[0]), .alu_a1(a1[0]), .alu_a2(a2[0]),
        .alu_d(alu_d[0]), .wb_valid(wbv[0]), .wb_dr(wbdr[0]), .wb_data(wbd[0]),
        .cc_n(ccn[0]), .cc_z(ccz[0]), .cc_p(ccp[0]), .br_valid(brv[0]), .br_taken(brt[0]),
        .br_offset(broff[0]), .illegal(ill[0])
    );

    lc3b_alu_issue #(.ALU_LAT(LAT1), .NREGS(8)) u_dut3 (
        .clk(clk), .reset(rst[1]), .instr_valid(iv[1]), .instr_ready(rdy[1]), .instr(iw[1]),
        .alu_opval(opv[1]), .alu_shiftop(shop[1]), .alu_amount4(amt[1]), .alu_a1(a1[1]), .alu_a2(a2[1]),
        .alu_d(alu_d[1]), .wb_valid(wbv[1]), .wb_dr(wbdr[1]), .wb_data(wbd[1]),
        .cc_n(ccn[1]), .cc_z(ccz[1]), .cc_p(ccp[1]), .br_valid(brv[1]), .br_taken(brt[1]),
        .br_offset(broff[1]), .illegal(ill[1])
    );

    // ALU responder: result appears ALU_LAT edges after the operands it saw.
    function automatic logic [15:0] bench_alu(input logic [1:0] op, input logic [1:0] sh,
                                              input logic [3:0] n, input logic [15:0] x,
                                              input logic [15:0] y);
        case (op)
            ALU_ADD: return x + y;
            ALU_AND: return x & y;
            ALU_XOR: return x ^ y;
            default: begin
                case (sh)
                    SH_RSHFL: return x >> n;
                    SH_RSHFA: return 16'($signed(x) >>> n);
                    default:  return x << n;
                endcase
            end
        endcase
    endfunction

    logic [15:0] pipe [2][3];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pipe[k][0] <= bench_alu(opv[k], shop[k], amt[k], a1[k], a2[k]);
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign alu_d[0] = pipe[0][LAT0-1];
    assign alu_d[1] = pipe[1][LAT1-1];

    // ---------------- behavioural model ----------------
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          en [2];
    int          age [2];
    logic [15:0] ir [2];
    logic [15:0] regs [2][8];
    logic [2:0]  cc [2];
    logic [15:0] res [2];
    logic [1:0]  e_op [2];
    logic [1:0]  e_sh [2];
    logic [3:0]  e_amt [2];
    logic [15:0] e_a1 [2];
    logic [15:0] e_a2 [2];
    bit          e_taken [2];
    bit          acc [2];
    int          acc_cyc [2];
    int          wb_cnt [2];
    int          br_cnt [2];
    int          ill_cnt [2];
    int          wb_cyc [2];
    logic [15:0] last_wb [2];
    logic        last_brt [2];
    logic [8:0]  last_broff [2];

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // 0 = ALU op, 1 = branch, 2 = unsupported
    function automatic int kind_of(input logic [15:0] w);
        case (w[15:12])
            4'd1, 4'd5, 4'd9, 4'd13: return 0;
            4'd0:                    return 1;
            default:                 return 2;
        endcase
    endfunction

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int busy_len(input int k, input logic [15:0] w);
        return (kind_of(w) == 0) ? 1 + lat_of(k) : 1;
    endfunction

    task automatic model_reset(input int k);
        for (int r = 0; r < 8; r++) regs[k][r] = 16'd0;
        cc[k] = 3'b010;
        age[k] = 0;
        e_op[k] = 2'd0; e_sh[k] = 2'd0; e_amt[k] = 4'd0; e_a1[k] = 16'd0; e_a2[k] = 16'd0;
        en[k] = 1'b1;
    endtask

    task automatic model_accept(input int k, input logic [15:0] w);
        logic [15:0] x, y;
        logic [3:0]  sa;
        ir[k] = w;
        age[k] = 1;
        acc[k] = 1'b1;
        acc_cyc[k] = cyc;
        if (kind_of(w) == 0) begin
            x = regs[k][w[8:6]];
            y = (w[5] && w[15:12] != 4'd13) ? {{11{w[4]}}, w[4:0]} : regs[k][w[2:0]];
            sa = w[3:0];
            case (w[15:12])
                4'd1: begin res[k] = x + y; e_op[k] = 2'd0; end
                4'd5: begin res[k] = x & y; e_op[k] = 2'd1; end
                4'd9: begin res[k] = x ^ y; e_op[k] = 2'd2; end
                default: begin
                    e_op[k] = 2'd3;
                    if (w[5:4] == 2'b00) res[k] = x << sa;
                    else if (w[5:4] == 2'b01) res[k] = x >> sa;
                    else res[k] = (x >> sa) | (x[15] ? ~(16'hFFFF >> sa) : 16'h0000);
                end
            endcase
            e_a1[k] = x;
            e_a2[k] = y;
            e_sh[k] = w[5:4];
            e_amt[k] = (w[15:12] == 4'd13) ? sa : 4'd0;
        end else if (kind_of(w) == 1) begin
            e_taken[k] = |(w[11:9] & cc[k]);
        end
    endtask

    initial begin
        en[0] = 1'b0;
        en[1] = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                acc[k] = 1'b0;
                if (rst[k]) begin
                    model_reset(k);
                end else if (age[k] == 0) begin
                    if (iv[k]) model_accept(k, iw[k]);
                end else if (age[k] == busy_len(k, ir[k])) begin
                    if (kind_of(ir[k]) == 0) begin
                        regs[k][ir[k][11:9]] = res[k];
                        cc[k] = nzp_of(res[k]);
                    end
                    age[k] = 0;
                end else begin
                    age[k]++;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare process: every DUT output against the model, once per cycle.
    initial begin
        for (int k = 0; k < 2; k++) begin
            wb_cnt[k] = 0; br_cnt[k] = 0; ill_cnt[k] = 0; wb_cyc[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (en[k]) begin
                    bit ew, eb, ei;
                    ew = (age[k] != 0) && kind_of(ir[k]) == 0 && age[k] == 1 + lat_of(k);
                    eb = (age[k] == 1) && kind_of(ir[k]) == 1;
                    ei = (age[k] == 1) && kind_of(ir[k]) == 2;
                    check($sformatf("L%0d instr_ready", k), rdy[k], age[k] == 0);
                    check($sformatf("L%0d wb_valid", k), wbv[k], ew);
                    check($sformatf("L%0d br_valid", k), brv[k], eb);
                    check($sformatf("L%0d illegal", k), ill[k], ei);
                    check($sformatf("L%0d cc", k), {ccn[k], ccz[k], ccp[k]}, cc[k]);
                    check($sformatf("L%0d alu_opval", k), opv[k], e_op[k]);
                    check($sformatf("L%0d alu_shiftop", k), shop[k], e_sh[k]);
                    check($sformatf("L%0d alu_amount4", k), amt[k], e_amt[k]);
                    check($sformatf("L%0d alu_a1", k), a1[k], e_a1[k]);
                    check($sformatf("L%0d alu_a2", k), a2[k], e_a2[k]);
                    if (ew) begin
                        check($sformatf("L%0d wb_dr", k), wbdr[k], ir[k][11:9]);
                        check($sformatf("L%0d wb_data", k), wbd[k], res[k]);
                    end
                    if (eb) begin
                        check($sformatf("L%0d br_taken", k), brt[k], e_taken[k]);
                        check($sformatf("L%0d br_offset", k), broff[k], ir[k][8:0]);
                    end
                    if (wbv[k] === 1'b1) begin
                        wb_cnt[k]++; wb_cyc[k] = cyc; last_wb[k] = wbd[k];
                    end
                    if (brv[k] === 1'b1) begin
                        br_cnt[k]++; last_brt[k] = brt[k]; last_broff[k] = broff[k];
                    end
                    if (ill[k] === 1'b1) ill_cnt[k]++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [15:0] w, input int hold, input int rst_after);
        int n;
        iw[k] = w;
        iv[k] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc[k] && n < 60);
        if (!acc[k]) check($sformatf("L%0d accept timeout", k), 0, 1);
        for (int i = 0; i < hold; i++) tick();
        iv[k] = 1'b0;
        iw[k] = 16'($urandom);
        if (rst_after >= 0) begin
            for (int i = 0; i < rst_after; i++) tick();
            rst[k] = 1'b1;
            tick();
            rst[k] = 1'b0;
        end
        n = 0;
        while (age[k] != 0 && n < 60) begin
            tick();
            n++;
        end
        if (age[k] != 0) check($sformatf("L%0d completion timeout", k), 0, 1);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        logic [3:0]  op;
        int          sel;
        w = 16'($urandom);
        sel = $urandom_range(0, 9);
        if (sel < 6) begin
            case ($urandom_range(0, 3))
                0: op = 4'd1;
                1: op = 4'd5;
                2: op = 4'd9;
                default: op = 4'd13;
            endcase
        end else if (sel < 8) begin
            op = 4'd0;
        end else begin
            do op = 4'($urandom); while (op inside {4'd0, 4'd1, 4'd5, 4'd9, 4'd13});
        end
        w[15:12] = op;
        if (op == 4'd13 && w[5:4] == 2'b10) w[5:4] = 2'b11;
        return w;
    endfunction

    initial begin
        int wbc, brc, illc;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; iv[k] = 1'b0; iw[k] = 16'h0000;
        end
        tick();
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        check("L0 reset ready", rdy[0], 1);
        check("L0 reset cc", {ccn[0], ccz[0], ccp[0]}, 3'b010);
        check("L0 reset pulses", {wbv[0], brv[0], ill[0]}, 3'b000);
        check("L0 reset alu_a1", a1[0], 16'h0000);

        // ADD R1,R0,#5
        issue(0, 16'h1225, 0, -1);
        check("add5 opval", opv[0], 2'b00);
        check("add5 a1", a1[0], 16'h0000);
        check("add5 a2", a2[0], 16'h0005);
        check("add5 wb_data", last_wb[0], 16'h0005);
        check("add5 model", res[0], 16'h0005);
        check("add5 latency", wb_cyc[0] - acc_cyc[0], 1);
        check("add5 cc", {ccn[0], ccz[0], ccp[0]}, 3'b001);
        // ADD R2,R1,#-6
        issue(0, 16'h147A, 0, -1);
        check("add-6 wb_data", last_wb[0], 16'hFFFF);
        check("add-6 cc", {ccn[0], ccz[0], ccp[0]}, 3'b100);
        // AND R3,R2,#0
        issue(0, 16'h56A0, 0, -1);
        check("and0 wb_data", last_wb[0], 16'h0000);
        check("and0 cc", {ccn[0], ccz[0], ccp[0]}, 3'b010);
        // SHF R4,R1 LSHF 4
        issue(0, 16'hD844, 0, -1);
        check("shf opval", opv[0], 2'b11);
        check("shf shiftop", shop[0], 2'b00);
        check("shf amount", amt[0], 4'd4);
        check("shf wb_data", last_wb[0], 16'h0050);
        check("shf model", regs[0][4], 16'h0050);
        // XOR R5,R1,R1
        issue(0, 16'h9A41, 0, -1);
        check("xor wb_data", last_wb[0], 16'h0000);
        check("xor cc", {ccn[0], ccz[0], ccp[0]}, 3'b010);
        // Branches against cc=010
        issue(0, 16'h0403, 0, -1);
        check("brz taken", last_brt[0], 1'b1);
        check("brz offset", last_broff[0], 9'd3);
        issue(0, 16'h0803, 0, -1);
        check("brn taken", last_brt[0], 1'b0);
        issue(0, 16'h0E00, 0, -1);
        check("brnzp taken", last_brt[0], 1'b1);
        brc = br_cnt[0];
        issue(0, 16'h0000, 0, -1);
        check("br000 taken", last_brt[0], 1'b0);
        check("br pulse count", br_cnt[0] - brc, 1);
        // TRAP is unsupported
        wbc = wb_cnt[0];
        illc = ill_cnt[0];
        issue(0, 16'hF025, 0, -1);
        check("trap illegal", ill_cnt[0] - illc, 1);
        check("trap no wb", wb_cnt[0] - wbc, 0);
        check("trap cc", {ccn[0], ccz[0], ccp[0]}, 3'b010);
        // ADD R1,R1,R1 with instr_valid held while busy
        wbc = wb_cnt[0];
        issue(0, 16'h1241, 2, -1);
        check("hold single wb", wb_cnt[0] - wbc, 1);
        check("dr=sr1 wb_data", last_wb[0], 16'h000A);

        // Latency 3: reset during WAIT drops the instruction
        iw[1] = 16'h1225;
        iv[1] = 1'b1;
        for (int n = 0; n < 20 && !acc[1]; n++) tick();
        iv[1] = 1'b0;
        tick();
        wbc = wb_cnt[1];
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        check("L1 ready after reset", rdy[1], 1'b1);
        check("L1 cc after reset", {ccn[1], ccz[1], ccp[1]}, 3'b010);
        for (int i = 0; i < 6; i++) tick();
        check("L1 dropped wb", wb_cnt[1] - wbc, 0);
        issue(1, 16'h1460, 0, -1);
        check("L1 R1 still zero", last_wb[1], 16'h0000);
        issue(1, 16'h1225, 0, -1);
        check("L1 add latency", wb_cyc[1] - acc_cyc[1], 3);
        check("L1 add wb_data", last_wb[1], 16'h0005);

        // Randomised traffic on both latencies
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 150; n++) begin
                int gap, hold, ra;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    iw[k] = 16'($urandom);
                    tick();
                end
                hold = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
                ra = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 3) : -1;
                issue(k, rand_instr(), hold, ra);
            end
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lc3b_alu_issue.md
Name: lc3b_alu_issue

Overview:
Issue/writeback controller that acts as initiator for the team's LC-3b ALU, which is the responder. It accepts 16-bit LC-3b instruction words over a valid/ready handshake and decodes ADD, AND, XOR and SHF. It reads operands from an internal 8x16 register file, drives the ALU opval/shiftop/amount4/A1/A2 inputs and captures the ALU result. It then writes back, updates the NZP condition codes and resolves BR against those codes.

Parameters:
ALU_LAT, 1, cycles from operands driven on alu_* until alu_d is valid (>=1)
NREGS, 8, register file depth (fixed by ISA; not intended to change)

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high
instr_valid  input  1  instruction word present
instr_ready  output  1  block can accept (high only in IDLE)
instr  input  16  LC-3b instruction word
alu_opval  output  2  00 ADD, 01 AND, 10 XOR, 11 SHF
alu_shiftop  output  2  ir[5:4]: 00 LSHF, 01 RSHFL, 11 RSHFA
alu_amount4  output  4  ir[3:0] for SHF, else 0
alu_a1  output  16  SR1 value
alu_a2  output  16  SR2 value or sign-extended imm5
alu_d  input  16  ALU result
wb_valid  output  1  one-cycle writeback pulse
wb_dr  output  3  destination register
wb_data  output  16  value written
cc_n, cc_z, cc_p  output  1 each  condition code register
br_valid  output  1  one-cycle branch-resolved pulse
br_taken  output  1  |(ir[11:9] & {n,z,p}), valid with br_valid
br_offset  output  9  ir[8:0], valid with br_valid
illegal  output  1  one-cycle pulse for unsupported opcode

Behaviour:
- Reset values: state IDLE; all regs R0..R7=0; cc={n,z,p}=010; all pulses 0; alu_* outputs 0; wb_dr/wb_data/br_offset 0.
- States: IDLE, EXEC, WAIT, WB, BRANCH, ILL.
- IDLE: instr_ready=1. A transfer occurs on an edge with instr_valid&instr_ready, which latches ir.
  - Opcode ir[15:12] 0001/0101/1001/1101 -> EXEC.
  - Opcode 0000 -> BRANCH.
  - Any other opcode -> ILL.
- EXEC (1 cycle): alu_a1=R[ir[8:6]].
  - alu_a2: if ir[5]=1 and opcode is not SHF, sext(ir[4:0]); else R[ir[2:0]].
  - alu_opval per opcode. SHF ignores alu_a2 (drive R[ir[2:0]]).
  - alu_* hold their values through WAIT.
  - Next state: if ALU_LAT=1 -> WB, else WAIT.
- WAIT: counter runs for ALU_LAT-1 cycles, then -> WB.
- WB (1 cycle):
  - wb_valid=1, wb_dr=ir[11:9], wb_data=alu_d.
  - At the end of the cycle: R[wb_dr]<=alu_d; n=alu_d[15], z=(alu_d==0), p=~n&~z.
  - Then -> IDLE.
- Latency: instruction accepted at edge T; wb_valid high in cycle T+1+ALU_LAT; instr_ready high again at T+2+ALU_LAT.
- No forwarding is needed: the next EXEC always reads the written-back value.
- BRANCH (1 cycle): br_valid=1; br_taken uses cc as it stands (the previous WB already completed); cc unchanged; -> IDLE. BR with nzp=000 is never taken; nzp=111 is always taken.
- ILL (1 cycle): illegal=1; no regfile or cc change; -> IDLE.
- The ALU is not re-driven outside EXEC/WAIT; alu_* keep their last values.
- Reset in any state: returns to IDLE next cycle. The in-flight instruction is dropped with no wb_valid, br_valid or illegal pulse; regs and cc return to reset values.
- instr is ignored while instr_ready=0; the sender must hold instr_valid.
- DR=SR1 (e.g. ADD R1,R1,R1) is legal: the read in EXEC precedes the write in WB.
- All arithmetic is 16-bit modulo with no overflow flag.

Decomposition:
- Shared package lc3b_pkg:
  - opcode constants (OP_BR=0000, OP_ADD=0001, OP_AND=0101, OP_XOR=1001, OP_SHF=1101)
  - ALU opval constants (ALU_ADD..ALU_SHF)
  - shiftop constants
  - state enum
  - sext5 helper
- One natural sub-module: lc3b_regfile (8x16; two async read ports, one sync write port, sync reset).

Test Plan:
- After reset: 0x1225 (ADD R1,R0,#5) -> alu_opval=00, a1=0, a2=5; wb_valid at T+2 with R1=0x0005; cc=001.
- 0x147A (ADD R2,R1,#-6) -> wb_data=0xFFFF, cc=100. Then 0x56A0 (AND R3,R2,#0) -> wb_data=0, cc=010.
- 0xD844 (SHF R4,R1 LSHF 4) -> alu_opval=11, shiftop=00, amount4=4, wb_data=0x0050. Then 0x9A41 (XOR R5,R1,R1, register mode) -> 0, cc=010.
- Branches with cc=010:
  - 0x0403 (BRz #3) -> br_valid, br_taken=1, br_offset=3.
  - 0x0803 (BRn) -> br_taken=0.
  - 0x0E00 -> taken.
  - 0x0000 -> not taken.
- 0xF025 (TRAP) -> illegal pulse, no wb_valid, cc and regs unchanged. Hold instr_valid during EXEC -> no second accept until instr_ready.
- ALU_LAT=3: assert reset in WAIT -> no wb_valid, R1 stays 0, cc=010, instr_ready=1 the cycle after reset deasserts. Re-run the ADD -> wb_valid at T+4.
